// File: rtl/mii_pcs_encoder.sv
// mii_pcs_encoder: 64b/66b BASE-R transmit encoder.
// Classifies each MII word, checks frame sequencing, builds a 66-bit block
// and optionally scrambles its payload with x^58+x^39+1.
module mii_pcs_encoder #(
    parameter int          SCRAMBLE      = 1,
    parameter logic [57:0] SCR_SEED      = 58'h3FFFFFFFFFFFFFF,
    parameter int          ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [63:0]              i_mii_data,
    input  logic [7:0]               i_mii_ctrl,
    output logic                     o_valid,
    output logic [65:0]              o_block,
    output logic                     o_seq_error,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] TYPE_C   = 8'h1E;
    localparam logic [7:0] TYPE_S   = 8'h78;
    localparam logic [6:0] CODE_ERR = 7'h1E;

    typedef enum logic {ST_C, ST_D} state_t;
    typedef enum logic [2:0] {CL_C, CL_S, CL_D, CL_T, CL_E} cls_t;

    state_t                   state_q, state_d;
    cls_t                     cls;
    logic [2:0]               term_lane;
    logic                     all_idle;
    logic                     blk_err;
    logic [1:0]               enc_sync, raw_sync;
    logic [63:0]              enc_pay, raw_pay, out_pay;
    logic [121:0]             scr_res;
    logic [57:0]              scr_q, scr_d;
    logic                     valid_q;
    logic [65:0]              block_q;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] cnt_q;

    // Terminate in lane k: data below k, 0xFD at k, idles above k.
    function automatic logic is_term(input logic [63:0] d, input logic [7:0] c, input int k);
        logic ok;
        ok = (c == (8'hFF << k)) && (d[8*k +: 8] == CH_TERM);
        for (int j = 0; j < 8; j++) begin
            if (j > k && d[8*j +: 8] != CH_IDLE) ok = 1'b0;
        end
        return ok;
    endfunction

    // Block type for a terminate in lane k.
    function automatic logic [7:0] term_type(input logic [2:0] k);
        logic [7:0] t;
        t = 8'h87;
        case (k)
            3'd0: t = 8'h87;
            3'd1: t = 8'h99;
            3'd2: t = 8'hAA;
            3'd3: t = 8'hB4;
            3'd4: t = 8'hCC;
            3'd5: t = 8'hD2;
            3'd6: t = 8'hE1;
            3'd7: t = 8'hFF;
        endcase
        return t;
    endfunction

    // Self-synchronous scrambler, LSB first; returns {next state, scrambled payload}.
    function automatic logic [121:0] scramble(input logic [63:0] din, input logic [57:0] st);
        logic [57:0] s;
        logic [63:0] dout;
        logic        b;
        s    = st;
        dout = '0;
        for (int i = 0; i < 64; i++) begin
            b       = din[i] ^ s[38] ^ s[57];
            dout[i] = b;
            s       = {s[56:0], b};
        end
        return {s, dout};
    endfunction

    // Classify the incoming MII word.
    always_comb begin
        cls       = CL_E;
        term_lane = 3'd0;
        all_idle  = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (i_mii_data[8*j +: 8] != CH_IDLE) all_idle = 1'b0;
        end
        if (i_mii_ctrl == 8'h00) begin
            cls = CL_D;
        end else if (i_mii_ctrl == 8'h01 && i_mii_data[7:0] == CH_START) begin
            cls = CL_S;
        end else if (i_mii_ctrl == 8'hFF && all_idle) begin
            cls = CL_C;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (is_term(i_mii_data, i_mii_ctrl, k)) begin
                    cls       = CL_T;
                    term_lane = 3'(k);
                end
            end
        end
    end

    // Sequencing FSM: next state and error decision.
    always_comb begin
        state_d = state_q;
        blk_err = 1'b0;
        case (state_q)
            ST_C: begin
                if (cls == CL_S) state_d = ST_D;
                else if (cls != CL_C) blk_err = 1'b1;
            end
            ST_D: begin
                if (cls == CL_T) begin
                    state_d = ST_C;
                end else if (cls != CL_D) begin
                    blk_err = 1'b1;
                    state_d = ST_C;
                end
            end
            default: state_d = ST_C;
        endcase
    end

    // Unscrambled block encoding for legal words.
    always_comb begin
        enc_sync = 2'b10;
        enc_pay  = '0;
        case (cls)
            CL_D: begin
                enc_sync = 2'b01;
                enc_pay  = i_mii_data;
            end
            CL_C: enc_pay[7:0] = TYPE_C;
            CL_S: enc_pay = {i_mii_data[63:8], TYPE_S};
            CL_T: begin
                enc_pay[7:0] = term_type(term_lane);
                for (int j = 0; j < 7; j++) begin
                    if (j < int'(term_lane)) enc_pay[8+8*j +: 8] = i_mii_data[8*j +: 8];
                end
            end
            default: enc_pay = '0;
        endcase
    end

    // Error substitution followed by optional scrambling of the payload.
    always_comb begin
        raw_sync = enc_sync;
        raw_pay  = enc_pay;
        if (blk_err) begin
            raw_sync     = 2'b10;
            raw_pay      = '0;
            raw_pay[7:0] = TYPE_C;
            for (int j = 0; j < 8; j++) raw_pay[8+7*j +: 7] = CODE_ERR;
        end
        scr_res = scramble(raw_pay, scr_q);
        if (SCRAMBLE != 0) begin
            out_pay = scr_res[63:0];
            scr_d   = scr_res[121:64];
        end else begin
            out_pay = raw_pay;
            scr_d   = scr_q;
        end
    end

    // FSM and scrambler state advance only on accepted words.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= ST_C;
            scr_q   <= SCR_SEED;
        end else if (i_valid) begin
            state_q <= state_d;
            scr_q   <= scr_d;
        end
    end

    // Output block register, error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            block_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= i_valid;
            err_q   <= i_valid & blk_err;
            if (i_valid) begin
                block_q <= {out_pay, raw_sync};
                if (blk_err && cnt_q != '1) cnt_q <= cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_block     = block_q;
    assign o_seq_error = err_q;
    assign o_err_count = cnt_q;

endmodule

// File: tb/tb_mii_pcs_encoder.sv
// Bench for mii_pcs_encoder: three instances (plain, scrambled, 4-bit counter)
// share one stimulus stream and are checked against a behavioural model.
module tb_mii_pcs_encoder;

    localparam int K_C  = 0;
    localparam int K_S  = 1;
    localparam int K_D  = 2;
    localparam int K_E  = 3;
    localparam int K_T0 = 8;
    localparam logic [7:0] TT [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    localparam logic [65:0] IDLE_BLK = {56'h0, 8'h1E, 2'b10};
    localparam logic [65:0] ERR_BLK  = {{8{7'h1E}}, 8'h1E, 2'b10};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [63:0] dat = '0;
    logic [7:0]  ctl = '0;

    logic        ov [3];
    logic [65:0] ob [3];
    logic        oe [3];
    logic [15:0] oc0, oc1;
    logic [3:0]  oc2;

    always #5 clk = ~clk;

    mii_pcs_encoder #(.SCRAMBLE(0), .ERR_CNT_WIDTH(16)) u0 (
        .clk(clk), .i_rst(rst), .i_valid(vld), .i_mii_data(dat), .i_mii_ctrl(ctl),
        .o_valid(ov[0]), .o_block(ob[0]), .o_seq_error(oe[0]), .o_err_count(oc0));
    mii_pcs_encoder #(.SCRAMBLE(1), .ERR_CNT_WIDTH(16)) u1 (
        .clk(clk), .i_rst(rst), .i_valid(vld), .i_mii_data(dat), .i_mii_ctrl(ctl),
        .o_valid(ov[1]), .o_block(ob[1]), .o_seq_error(oe[1]), .o_err_count(oc1));
    mii_pcs_encoder #(.SCRAMBLE(0), .ERR_CNT_WIDTH(4)) u2 (
        .clk(clk), .i_rst(rst), .i_valid(vld), .i_mii_data(dat), .i_mii_ctrl(ctl),
        .o_valid(ov[2]), .o_block(ob[2]), .o_seq_error(oe[2]), .o_err_count(oc2));

    int nvec  = 0;
    int nfail = 0;

    // Model state
    bit          started = 1'b0;
    bit          in_frame [3];
    logic        exp_v [3];
    logic [65:0] exp_b [3];
    logic        exp_e [3];
    int          exp_c [3];
    int          cmax  [3] = '{65535, 65535, 15};
    bit          hist [$];
    logic [65:0] exp_raw1;
    bit          desc_clear = 1'b0;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic int kind_of(input logic [63:0] d, input logic [7:0] c);
        logic [7:0] ln [8];
        bit idle_all, ok;
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        if (c == 8'h00) return K_D;
        if (c == 8'h01 && ln[0] == 8'hFB) return K_S;
        idle_all = 1'b1;
        for (int i = 0; i < 8; i++) if (ln[i] != 8'h07) idle_all = 1'b0;
        if (c == 8'hFF && idle_all) return K_C;
        for (int k = 0; k < 8; k++) begin
            ok = (int'(c) == 255 - ((1 << k) - 1)) && (ln[k] == 8'hFD);
            for (int i = k + 1; i < 8; i++) if (ln[i] != 8'h07) ok = 1'b0;
            if (ok) return K_T0 + k;
        end
        return K_E;
    endfunction

    function automatic logic [65:0] enc_ref(input int kd, input logic [63:0] d);
        logic [63:0] p;
        int k;
        p = '0;
        if (kd == K_D) return {d, 2'b01};
        if (kd == K_C) return IDLE_BLK;
        if (kd == K_S) return {d[63:8], 8'h78, 2'b10};
        k = kd - K_T0;
        p[7:0] = TT[k];
        for (int j = 0; j < k; j++) p[8+8*j +: 8] = d[8*j +: 8];
        return {p, 2'b10};
    endfunction

    function automatic logic [65:0] err_ref();
        logic [63:0] p;
        p = '0;
        p[7:0] = 8'h1E;
        for (int j = 0; j < 8; j++) p[8+7*j +: 7] = 7'h1E;
        return {p, 2'b10};
    endfunction

    task automatic model_update();
        int kd;
        bit bad;
        logic [65:0] raw, blk;
        bit b;
        if (rst) begin
            started = 1'b1;
            desc_clear = 1'b1;
            hist = {};
            for (int i = 0; i < 58; i++) hist.push_back(1'b1);
            for (int u = 0; u < 3; u++) begin
                in_frame[u] = 1'b0; exp_v[u] = 1'b0; exp_b[u] = '0; exp_e[u] = 1'b0; exp_c[u] = 0;
            end
            return;
        end
        kd = kind_of(dat, ctl);
        for (int u = 0; u < 3; u++) begin
            exp_v[u] = vld;
            exp_e[u] = 1'b0;
            if (vld) begin
                if (in_frame[u]) bad = !(kd == K_D || kd >= K_T0);
                else             bad = !(kd == K_C || kd == K_S);
                in_frame[u] = in_frame[u] ? (kd == K_D) : (kd == K_S);
                raw = bad ? err_ref() : enc_ref(kd, dat);
                blk = raw;
                if (u == 1) begin
                    exp_raw1 = raw;
                    for (int i = 0; i < 64; i++) begin
                        b = raw[2+i] ^ hist[hist.size()-1-38] ^ hist[hist.size()-1-57];
                        blk[2+i] = b;
                        hist.push_back(b);
                        void'(hist.pop_front());
                    end
                end
                exp_b[u] = blk;
                exp_e[u] = bad;
                if (bad && exp_c[u] < cmax[u]) exp_c[u]++;
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [63:0] d, input logic [7:0] c);
        @(negedge clk);
        rst = r; vld = v; dat = d; ctl = c;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle compare of all instances against the model, plus descrambler check.
    initial begin
        logic [57:0] ds;
        logic [63:0] rec;
        logic        rx;
        int          dcnt;
        logic [15:0] ocv;
        ds = '0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (started) begin
                if (desc_clear) begin
                    ds = '0; dcnt = 0; desc_clear = 1'b0;
                end
                for (int u = 0; u < 3; u++) begin
                    ocv = (u == 0) ? oc0 : (u == 1) ? oc1 : {12'h0, oc2};
                    chk($sformatf("u%0d o_valid", u), ov[u], exp_v[u]);
                    chk($sformatf("u%0d o_block", u), ob[u], exp_b[u]);
                    chk($sformatf("u%0d o_seq_error", u), oe[u], exp_e[u]);
                    chk($sformatf("u%0d o_err_count", u), ocv, exp_c[u]);
                end
                if (ov[1] === 1'b1) begin
                    for (int i = 0; i < 64; i++) begin
                        rx = ob[1][2+i];
                        rec[i] = rx ^ ds[38] ^ ds[57];
                        ds = {ds[56:0], rx};
                    end
                    if (dcnt > 0) chk("u1 descrambled payload", rec, exp_raw1[65:2]);
                    chk("u1 sync header", ob[1][1:0], exp_raw1[1:0]);
                    dcnt++;
                end
            end
        end
    end

    // Directed and random stimulus
    initial begin
        logic [63:0] d;
        logic [7:0]  c;
        int          k, nd;

        step(1, 0, '0, '0);
        chk("reset o_valid", ov[0], 1'b0);
        chk("reset o_block", ob[0], 66'h0);
        chk("reset o_seq_error", oe[0], 1'b0);
        chk("reset o_err_count", oc0, 16'h0);

        // Idle and a short frame
        step(0, 1, 64'h0707070707070707, 8'hFF);
        chk("idle block", ob[0], IDLE_BLK);
        chk("idle valid", ov[0], 1'b1);
        chk("idle no error", oe[0], 1'b0);
        step(0, 1, 64'hD5555555555555FB, 8'h01);
        chk("start block", ob[0], {56'hD5555555555555, 8'h78, 2'b10});
        step(0, 1, 64'hAAAAAAAAAAAAAAAA, 8'h00);
        chk("data block", ob[0], {64'hAAAAAAAAAAAAAAAA, 2'b01});
        step(0, 1, 64'h07070707FD332211, 8'hF8);
        chk("term3 block", ob[0], {32'h0, 8'h33, 8'h22, 8'h11, 8'hB4, 2'b10});
        chk("frame err count", oc0, 16'h0);

        // Bubble mid-frame, then reset inside the frame
        step(0, 1, 64'hD5555555555555FB, 8'h01);
        step(0, 1, 64'hAAAAAAAAAAAAAAAA, 8'h00);
        step(0, 0, 64'h0123456789ABCDEF, 8'h5A);
        chk("bubble o_valid", ov[0], 1'b0);
        chk("bubble hold", ob[0], {64'hAAAAAAAAAAAAAAAA, 2'b01});
        step(0, 1, 64'h5555555555555555, 8'h00);
        chk("after bubble data", ob[0], {64'h5555555555555555, 2'b01});
        chk("after bubble no error", oe[0], 1'b0);
        step(1, 1, 64'h5555555555555555, 8'h00);
        chk("mid-frame reset block", ob[0], 66'h0);
        chk("mid-frame reset valid", ov[0], 1'b0);
        step(0, 1, 64'hAAAAAAAAAAAAAAAA, 8'h00);
        chk("seq error block", ob[0], ERR_BLK);
        chk("seq error pulse", oe[0], 1'b1);
        chk("seq error count", oc0, 16'd1);
        step(0, 1, 64'h0707070707070707, 8'hFF);
        chk("idle after error", ob[0], IDLE_BLK);
        chk("pulse cleared", oe[0], 1'b0);

        // Random legal frames with occasional bubbles
        step(1, 0, '0, '0);
        for (int f = 0; f < 1000; f++) begin
            nd = $urandom_range(0, 2);
            for (int i = 0; i < nd; i++) step(0, 1, 64'h0707070707070707, 8'hFF);
            d = {$urandom, $urandom};
            d[7:0] = 8'hFB;
            step(0, 1, d, 8'h01);
            nd = $urandom_range(0, 3);
            for (int i = 0; i < nd; i++) begin
                if ($urandom_range(0, 7) == 0) step(0, 0, {$urandom, $urandom}, 8'($urandom));
                step(0, 1, {$urandom, $urandom}, 8'h00);
            end
            k = $urandom_range(0, 7);
            d = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) begin
                if (j == k) d[8*j +: 8] = 8'hFD;
                else if (j > k) d[8*j +: 8] = 8'h07;
            end
            c = 8'hFF;
            c = c << k;
            step(0, 1, d, c);
        end

        // Counter saturation on the 4-bit instance
        step(1, 0, '0, '0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 64'hFEFEFEFEFEFEFEFE, 8'hFF);
            chk("sat pulse", oe[2], 1'b1);
            chk("sat count", oc2, (i + 1 < 15) ? 4'(i + 1) : 4'hF);
        end
        step(0, 0, '0, '0);
        chk("sat final", oc2, 4'hF);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mii_pcs_encoder.md
Name: mii_pcs_encoder

Overview:
64b/66b PCS transmit encoder for the BASE-R path. It sits directly downstream of the MAC/MII frame generator and consumes its 64-bit MII data and 8-bit control stream. For each input word it classifies the word, checks that the frame sequence is legal, and emits one 66-bit block. An optional self-synchronous scrambler is applied to the block payload. The output feeds the gearbox/serializer and a loopback checker.

Parameters:
SCRAMBLE, 1, 1 = scramble the 64-bit payload with x^58+x^39+1; 0 = bypass.
SCR_SEED, 58'h3FFFFFFFFFFFFFF, scrambler state loaded at reset.
ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_valid  in  1  qualifies i_mii_data and i_mii_ctrl.
i_mii_data  in  64  lane k = bits [8k+7:8k]; lane 0 is first on the wire.
i_mii_ctrl  in  8  bit k = 1 means lane k is a control character.
o_valid  out  1  o_block is valid this cycle.
o_block  out  66  [1:0] = sync header, [65:2] = payload; payload[7:0] is the block type.
o_seq_error  out  1  one-cycle pulse when an error block is emitted.
o_err_count  out  ERR_CNT_WIDTH  number of error blocks emitted, saturating.

Behaviour:
- Reset, sampled on the clk edge:
  - o_valid = 0, o_block = 0, o_seq_error = 0, o_err_count = 0.
  - FSM = ST_C; scrambler state = SCR_SEED.
  - Reset overrides i_valid in the same cycle.
  - A reset in mid-frame aborts the frame without emitting an error block.
- Latency and handshake:
  - Exactly 1 cycle: input with i_valid=1 at edge n produces o_valid=1 at edge n+1.
  - No backpressure.
  - When i_valid=0: o_valid=0 next cycle, o_block holds its last value, FSM and scrambler state are unchanged.
- Input classification (combinational). Legal control characters are 0x07 idle, 0xFB start, 0xFD terminate, 0xFE error.
  - D: ctrl = 8'h00.
  - C: ctrl = 8'hFF and every lane = 0x07.
  - S: ctrl = 8'h01 and lane 0 = 0xFB.
  - T_k (k = 0..7): lanes < k are data; lane k = 0xFD; lanes > k are 0x07 control; ctrl = 8'hFF << k.
  - E: anything else, including any 0xFE lane, start in a lane other than 0, or an illegal control code.
- Block encoding before scrambling:
  - D: sync 2'b01; payload = i_mii_data.
  - C: sync 2'b10; type 0x1E; remaining 56 bits = 0 (eight 7-bit idle codes of 0x00).
  - S: sync 2'b10; type 0x78; payload bytes 1..7 = lanes 1..7.
  - T_k: sync 2'b10; type = {0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF}[k]; payload bytes 1..k = lanes 0..k-1; the upper 56-8k bits = 0.
  - Error block: sync 2'b10; type 0x1E; then eight 7-bit codes of 7'h1E, code j at payload bits [8+7j+6 : 8+7j].
- Sequencing FSM (states ST_C, ST_D):
  - ST_C: C → ST_C; S → ST_D; D, T_k or E → error block, stay in ST_C.
  - ST_D: D → ST_D; T_k → ST_C; C, S or E → error block, go to ST_C.
  - The FSM advances only on i_valid=1.
- Errors:
  - Every error block pulses o_seq_error for 1 cycle, aligned with its o_valid.
  - Every error block increments o_err_count by 1; the counter saturates at all-ones and does not wrap.
- Scrambler (SCRAMBLE=1):
  - Applied to payload bits 0..63 in LSB-first order; the sync header is never scrambled.
  - S[57:0] holds the last 58 scrambled bits, S[0] newest.
  - For each bit: out = in ^ S[38] ^ S[57]; then S = {S[56:0], out}.
  - All 64 bit-steps complete within one cycle, on each i_valid=1 cycle.
  - SCRAMBLE=0: the payload passes through and S is unused.

Test Plan:
- Idle, SCRAMBLE=0: i_valid=1, data 64'h0707070707070707, ctrl 8'hFF → next cycle o_valid=1, o_block = {56'h0, 8'h1E, 2'b10}, o_seq_error=0.
- Frame, SCRAMBLE=0:
  - Input sequence: C, then S (data 64'hD5555555555555FB, ctrl 8'h01), then D (64'hAAAAAAAAAAAAAAAA, ctrl 8'h00), then T_3 (lanes 0..2 = 11,22,33; lane 3 = FD; lanes 4..7 = 07; ctrl 8'hF8).
  - Expected blocks: {56'h0,8'h1E,2'b10}; {56'hD5555555555555,8'h78,2'b10}; {64'hAAAAAAAAAAAAAAAA,2'b01}; {32'h0,8'h33,8'h22,8'h11,8'hB4,2'b10}.
  - o_err_count stays 0.
- Sequence error: after reset, apply D (ctrl 8'h00) → error block with type 0x1E and codes 7'h1E, o_seq_error pulse, o_err_count=1. A following C → normal idle block.
- Bubbles and reset:
  - Toggle i_valid 1,0,1 in the middle of a frame → o_valid follows with 1-cycle delay, o_block holds during the gap, no error.
  - Assert i_rst in ST_D → all outputs 0 next cycle; a subsequent D yields an error block (FSM back in ST_C).
- Scrambler, SCRAMBLE=1, default seed:
  - Drive 1000 random legal frames.
  - Compare against the bench reference model bit-exactly.
  - Pass output through a self-synchronous descrambler: after the first block, the recovered payloads equal the unscrambled encoding.
  - Sync headers are never altered.
- Saturation: with ERR_CNT_WIDTH=4, apply 20 consecutive E words (ctrl 8'hFF, all lanes 0xFE) → o_err_count saturates and stays at 4'hF, with a pulse each cycle.
